// File: rtl/hvc007_keyboard_scanner_pkg.sv
// hvc007_pkg: keyboard matrix geometry, scan states and key indexing.
// Shared by the host scanner and the device-side keyboard emulator.
package hvc007_pkg;
    localparam int HVC007_ROWS = 9;
    localparam int HVC007_COLS = 2;
    localparam int HVC007_BITS = 4;
    localparam int HVC007_KEYS = HVC007_ROWS * HVC007_COLS * HVC007_BITS;
    typedef enum logic [2:0] {S_IDLE, S_RST, S_C0, S_C1, S_PROBE, S_COMMIT} scan_state_t;
    // row*8 + col*4 + bit is exactly the concatenation of the three fields
    function automatic logic [6:0] key_idx(input logic [3:0] row, input logic col, input logic [1:0] b);
        return {row, col, b};
    endfunction
endpackage

// File: rtl/hvc007_keyboard_scanner_if.sv
// hvc007_keyboard_scanner_if: $4016 strobes, $4017 nibble and published key bitmap.
interface hvc007_keyboard_scanner_if;
    import hvc007_pkg::*;
    logic                   o_reset_first_row;
    logic                   o_select_column;
    logic                   o_matrix_enable;
    logic [3:0]             i_kbd_data;
    logic [HVC007_KEYS-1:0] o_matrix;
    logic                   o_matrix_valid;
    logic                   o_present;
    logic                   o_busy;
    modport master (
        output o_reset_first_row, o_select_column, o_matrix_enable,
        input  i_kbd_data,
        output o_matrix, o_matrix_valid, o_present, o_busy
    );
    modport slave (
        input  o_reset_first_row, o_select_column, o_matrix_enable,
        output i_kbd_data,
        input  o_matrix, o_matrix_valid, o_present, o_busy
    );
endinterface

// File: rtl/hvc007_keyboard_scanner_settle_timer.sv
// hvc007_settle_timer: dwell counter; o_done marks the last i_ce cycle of a strobe state.
module hvc007_settle_timer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_ce,
    input  logic i_load,
    output logic o_done
);
    localparam int TW = $clog2(SETTLE_CYCLES);
    logic [TW-1:0] cnt_q;
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) cnt_q <= '0;
        else if (i_load) cnt_q <= TW'(SETTLE_CYCLES - 1);
        else if (i_ce && cnt_q != '0) cnt_q <= cnt_q - TW'(1);
    end
    assign o_done = cnt_q == '0;
endmodule

// File: rtl/hvc007_keyboard_scanner.sv
// hvc007_keyboard_scanner: periodic HVC-007 matrix scan publishing a 72-bit key bitmap.
// Build option SCANNER_DEBOUNCE_EN: a bitmap bit changes only after two agreeing scans.
module hvc007_keyboard_scanner
    import hvc007_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int SCAN_PERIOD   = 357954
) (
    input logic i_clk,
    input logic i_reset_n,
    input logic i_ce,
    hvc007_keyboard_scanner_if.master bus
);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
    scan_state_t            state_q;
    logic [3:0]             row_q;
    logic [PW-1:0]          period_q;
    logic                   pend_q, rst_row_q, col_q, en_q, valid_q, present_q, busy_q;
    logic [HVC007_KEYS-1:0] raw_q, matrix_q, commit_d;
    logic                   wrap_d, start_d, load_d, done_d, probe_d;
`ifdef SCANNER_DEBOUNCE_EN
    logic [HVC007_KEYS-1:0] prev_q;
`endif
    hvc007_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_ce     (i_ce),
        .i_load   (load_d),
        .o_done   (done_d)
    );
    always_comb begin
        wrap_d  = period_q == PERIOD_LAST;
        // a wrap seen mid-scan stays pending so an overlong scan restarts right after COMMIT
        start_d = state_q == S_IDLE && (pend_q || wrap_d);
        load_d  = i_ce && (state_q == S_IDLE ? start_d : done_d);
        probe_d = bus.i_kbd_data == 4'b0000;
`ifdef SCANNER_DEBOUNCE_EN
        commit_d = probe_d ? (matrix_q & (raw_q ^ prev_q)) | (raw_q & ~(raw_q ^ prev_q)) : '0;
`else
        commit_d = probe_d ? raw_q : '0;
`endif
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            period_q  <= '0;
            pend_q    <= 1'b1;
            rst_row_q <= 1'b0;
            col_q     <= 1'b0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
            busy_q    <= 1'b0;
            raw_q     <= '0;
            matrix_q  <= '0;
`ifdef SCANNER_DEBOUNCE_EN
            prev_q    <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (i_ce) begin
                period_q <= start_d || wrap_d ? '0 : period_q + PW'(1);
                pend_q   <= start_d ? 1'b0 : pend_q | wrap_d;
                case (state_q)
                    S_IDLE: if (start_d) begin
                        state_q   <= S_RST;
                        row_q     <= '0;
                        rst_row_q <= 1'b1;
                        col_q     <= 1'b0;
                        en_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                    S_RST: if (done_d) begin
                        state_q   <= S_C0;
                        rst_row_q <= 1'b0;
                    end
                    S_C0: if (done_d) begin
                        raw_q[key_idx(row_q, 1'b0, 2'd0) +: HVC007_BITS] <= ~bus.i_kbd_data;
                        state_q <= S_C1;
                        col_q   <= 1'b1;
                    end
                    S_C1: if (done_d) begin
                        raw_q[key_idx(row_q, 1'b1, 2'd0) +: HVC007_BITS] <= ~bus.i_kbd_data;
                        state_q <= row_q == 4'(HVC007_ROWS - 1) ? S_PROBE : S_C0;
                        row_q   <= row_q == 4'(HVC007_ROWS - 1) ? row_q : row_q + 4'd1;
                        col_q   <= 1'b0;
                    end
                    S_PROBE: if (done_d) begin
                        state_q   <= S_COMMIT;
                        en_q      <= 1'b0;
                        present_q <= probe_d;
                        matrix_q  <= commit_d;
                        valid_q   <= 1'b1;
`ifdef SCANNER_DEBOUNCE_EN
                        prev_q    <= raw_q;
`endif
                    end
                    S_COMMIT: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
    assign bus.o_reset_first_row = rst_row_q;
    assign bus.o_select_column   = col_q;
    assign bus.o_matrix_enable   = en_q;
    assign bus.o_matrix          = matrix_q;
    assign bus.o_matrix_valid    = valid_q;
    assign bus.o_present         = present_q;
    assign bus.o_busy            = busy_q;
endmodule

// File: tb/tb_hvc007_keyboard_scanner.sv
// tb_hvc007_keyboard_scanner: keyboard model plus scoreboard on each o_matrix_valid pulse.
module tb_hvc007_keyboard_scanner;
    import hvc007_pkg::*;
    localparam int SETTLE   = 4;
    localparam int PERIOD   = 100;
    localparam int SCAN_LEN = 20 * SETTLE + 1;
    logic clk = 1'b0, reset_n = 1'b0, ce = 1'b1, half = 1'b0, absent = 1'b0;
    logic [HVC007_KEYS-1:0] keys = '0;
    logic [3:0] kb_row = '0;
    logic kb_col = 1'b0, busy_prev = 1'b0, col_prev = 1'b0;
    int checks = 0, errors = 0, n_valid = 0, busy_cnt = 0, col_falls = 0, rst_hi = 0;
    int cyc = 0, st_prev = 0, st_last = 0, wait_n = 0;
    logic [72:0] exp_q[$];
    logic [72:0] e;
    logic [71:0] m_prev = '0, m_mat = '0, k30, k71;
    logic [71:0] seq [6];

    hvc007_keyboard_scanner_if bus();
    hvc007_keyboard_scanner #(.SETTLE_CYCLES(SETTLE), .SCAN_PERIOD(PERIOD)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // keyboard: reset strobe homes the row, column 1->0 advances it, row 9 answers 0000
    always @(posedge clk) begin
        if (bus.o_reset_first_row) kb_row <= '0;
        else if (kb_col && !bus.o_select_column) kb_row <= kb_row + 4'd1;
        kb_col <= bus.o_select_column;
    end
    always_comb bus.i_kbd_data = (absent || !bus.o_matrix_enable) ? 4'hF :
        (kb_row < 4'd9 ? ~keys[{kb_row, bus.o_select_column, 2'b00} +: 4] : 4'h0);

    initial forever begin
        @(negedge clk);
        ce = half ? ~ce : 1'b1;
    end

    always @(negedge clk) begin
        if (bus.o_busy) busy_cnt++;
        if (bus.o_busy && !busy_prev) begin
            st_prev = st_last;
            st_last = cyc;
        end
        if (bus.o_busy && col_prev && !bus.o_select_column) col_falls++;
        if (bus.o_reset_first_row) rst_hi++;
        busy_prev = bus.o_busy;
        col_prev  = bus.o_select_column;
        if (bus.o_matrix_valid) begin
            n_valid++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got matrix=%h present=%b, required no pulse", bus.o_matrix, bus.o_present);
            end else begin
                e = exp_q.pop_front();
                if ({bus.o_matrix, bus.o_present} !== e) begin
                    errors++;
                    $display("FAIL scoreboard_%0d: got matrix=%h present=%b, required matrix=%h present=%b",
                             n_valid, bus.o_matrix, bus.o_present, e[72:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic expect_scan(input logic [71:0] k, input logic abs);
        logic [71:0] raw, m;
        raw = abs ? '0 : k;
        for (int i = 0; i < 72; i++) begin
`ifdef SCANNER_DEBOUNCE_EN
            m[i] = raw[i] == m_prev[i] ? raw[i] : m_mat[i];
`else
            m[i] = raw[i];
`endif
        end
        if (abs) m = '0;
        m_prev = raw;
        m_mat  = m;
        keys   = k;
        absent = abs;
        exp_q.push_back({m, ~abs});
    endtask

    task automatic wait_valid(input int target, input int bound);
        int n = 0;
        while (n_valid < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n_valid < target) begin
            checks++;
            errors++;
            $display("FAIL timeout_valid: got %0d pulses, required %0d", n_valid, target);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.o_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", bus.o_busy, 0);
    endtask

    task automatic clr_stats();
        @(posedge clk);
        busy_cnt  = 0;
        col_falls = 0;
        rst_hi    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_prev = '0;
        m_mat  = '0;
        check("reset_outputs", {bus.o_reset_first_row, bus.o_select_column, bus.o_matrix_enable, bus.o_matrix,
                                bus.o_matrix_valid, bus.o_present, bus.o_busy}, 0);
    endtask

    initial begin
        k30 = 72'd1 << 30;
        k71 = 72'd1 << 71;
        seq = '{k30, k30, k71, '0, k71, k71};
        do_reset();
        expect_scan('0, 1'b0);
        clr_stats();
        @(negedge clk);
        reset_n = 1'b1;
        wait_valid(1, 400);
        wait_idle();
        check("scan_busy_clocks", busy_cnt, SCAN_LEN);
        check("column_falls", col_falls, 9);
        check("reset_strobe_clocks", rst_hi, SETTLE);
        expect_scan('0, 1'b0);
        clr_stats();
        wait_valid(2, 400);
        wait_idle();
        check("scan_period", st_last - st_prev, PERIOD);
        for (int i = 0; i < 6; i++) begin
            expect_scan(seq[i], 1'b0);
            wait_valid(3 + i, 400);
            wait_idle();
        end
        wait_n = 0;
        while (!(bus.o_busy && kb_row == 4'd4 && bus.o_select_column) && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        check("reach_row4_c1", bus.o_busy && kb_row == 4'd4 && bus.o_select_column, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_outputs", {bus.o_reset_first_row, bus.o_select_column, bus.o_matrix_enable, bus.o_matrix,
                                bus.o_matrix_valid, bus.o_present, bus.o_busy}, 0);
        do_reset();
        expect_scan(k30, 1'b1);
        clr_stats();
        @(negedge clk);
        reset_n = 1'b1;
        wait_valid(9, 400);
        wait_idle();
        check("absent_valid_count", n_valid, 9);
        do_reset();
        half = 1'b1;
        expect_scan(k30, 1'b0);
        clr_stats();
        @(negedge clk);
        reset_n = 1'b1;
        wait_valid(10, 800);
        wait_idle();
        check("half_busy_clocks", busy_cnt, 2 * SCAN_LEN);
        check("half_column_falls", col_falls, 9);
        check("half_reset_strobe_clocks", rst_hi, 2 * SETTLE);
        expect_scan(k30, 1'b0);
        wait_valid(11, 800);
        wait_idle();
        half = 1'b0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
